integrator_fifo_sequencer: RTL and testbench

INTEGRATOR_FIFO_SEQUENCER -- requirements
Module: integrator_fifo_sequencer

---
 rtl/integrator_fifo_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_integrator_fifo_sequencer.sv | 550 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/integrator_fifo_sequencer.sv
// ---------------------------------------------------------------------------
// integrator_fifo_sequencer
//
// Serialises a frame of CHANNELS integrator sums into an external word-wide
// FIFO (push engine). A second engine reads one frame back out of that FIFO
// and presents it as a parallel word (pop engine). The two engines are fully
// independent and may run on the same cycle.
//
// Ports
//   clk           sole clock, rising edge
//   reset         synchronous, active-high
//   in_load       strobe: capture in_sums and start pushing it
//   in_sums       CHANNELS packed sums, channel i at [i*WIDTH +: WIDTH]
//   fifo_wr_en    external FIFO write enable
//   fifo_wr_data  external FIFO write word
//   fifo_full     external FIFO full (stalls the push engine)
//   pop_start     strobe: read one frame from the FIFO
//   fifo_rd_en    external FIFO read enable (data returns one cycle later)
//   fifo_rd_data  external FIFO read word
//   fifo_empty    external FIFO empty (stalls read issue)
//   out_sums      last fully popped frame, same packing as in_sums
//   out_valid     one-cycle pulse when out_sums is updated
//   push_busy     push engine not idle
//   pop_busy      pop engine not idle
//   load_overrun  sticky: in_load seen while the push engine was busy
//   pop_overrun   sticky: pop_start seen while the pop engine was busy
// ---------------------------------------------------------------------------
module integrator_fifo_sequencer #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 36
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_load,
    input  logic [CHANNELS*WIDTH-1:0] in_sums,
    output logic                      fifo_wr_en,
    output logic [WIDTH-1:0]          fifo_wr_data,
    input  logic                      fifo_full,
    input  logic                      pop_start,
    output logic                      fifo_rd_en,
    input  logic [WIDTH-1:0]          fifo_rd_data,
    input  logic                      fifo_empty,
    output logic [CHANNELS*WIDTH-1:0] out_sums,
    output logic                      out_valid,
    output logic                      push_busy,
    output logic                      pop_busy,
    output logic                      load_overrun,
    output logic                      pop_overrun
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = $clog2(CHANNELS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] CHAN_CNT = CNT_W'(CHANNELS);

    typedef enum logic {
        P_IDLE,
        P_PUSH
    } push_state_t;

    typedef enum logic [1:0] {
        O_IDLE,
        O_READ,
        O_DONE
    } pop_state_t;

    // -----------------------------------------------------------------------
    // Channel unpack / pack
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] in_word      [CHANNELS];
    logic [WIDTH-1:0] out_word_reg [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign in_word[gi]                   = in_sums[gi*WIDTH +: WIDTH];
            assign out_sums[gi*WIDTH +: WIDTH]   = out_word_reg[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Push engine
    // -----------------------------------------------------------------------
    push_state_t      push_state_reg;
    logic [IDX_W-1:0] push_idx_reg;
    logic [WIDTH-1:0] cap_reg [CHANNELS];
    logic             load_overrun_reg;

    // Write enable follows fifo_full combinationally so a full FIFO costs no
    // extra bubble once it drains.
    assign fifo_wr_en   = (push_state_reg == P_PUSH) && !fifo_full;
    assign fifo_wr_data = cap_reg[push_idx_reg];
    assign push_busy    = (push_state_reg != P_IDLE);
    assign load_overrun = load_overrun_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            push_state_reg   <= P_IDLE;
            push_idx_reg     <= '0;
            load_overrun_reg <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cap_reg[i] <= '0;
            end
        end else begin
            case (push_state_reg)
                P_IDLE: begin
                    if (in_load) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            cap_reg[i] <= in_word[i];
                        end
                        push_idx_reg   <= '0;
                        push_state_reg <= P_PUSH;
                    end
                end
                P_PUSH: begin
                    // A load mid-frame is dropped; the captured frame stays intact.
                    if (in_load) begin
                        load_overrun_reg <= 1'b1;
                    end
                    if (fifo_wr_en) begin
                        if (push_idx_reg == LAST_IDX) begin
                            push_idx_reg   <= '0;
                            push_state_reg <= P_IDLE;
                        end else begin
                            push_idx_reg <= push_idx_reg + IDX_W'(1);
                        end
                    end
                end
                default: push_state_reg <= P_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Pop engine
    // -----------------------------------------------------------------------
    pop_state_t       pop_state_reg;
    logic [CNT_W-1:0] issued_reg;
    logic [IDX_W-1:0] recv_reg;
    logic             rd_pending_reg;
    logic [WIDTH-1:0] shadow_reg [CHANNELS];
    logic             out_valid_reg;
    logic             pop_overrun_reg;

    assign fifo_rd_en  = (pop_state_reg == O_READ) && !fifo_empty && (issued_reg < CHAN_CNT);
    assign pop_busy    = (pop_state_reg != O_IDLE);
    assign out_valid   = out_valid_reg;
    assign pop_overrun = pop_overrun_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pop_state_reg   <= O_IDLE;
            issued_reg      <= '0;
            recv_reg        <= '0;
            rd_pending_reg  <= 1'b0;
            out_valid_reg   <= 1'b0;
            pop_overrun_reg <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_reg[i]   <= '0;
                out_word_reg[i] <= '0;
            end
        end else begin
            out_valid_reg  <= 1'b0;
            // Marks the cycle on which fifo_rd_data carries a requested word.
            rd_pending_reg <= fifo_rd_en;

            case (pop_state_reg)
                O_IDLE: begin
                    if (pop_start) begin
                        issued_reg    <= '0;
                        recv_reg      <= '0;
                        pop_state_reg <= O_READ;
                    end
                end
                O_READ: begin
                    if (pop_start) begin
                        pop_overrun_reg <= 1'b1;
                    end
                    if (fifo_rd_en) begin
                        issued_reg <= issued_reg + CNT_W'(1);
                    end
                    if (rd_pending_reg) begin
                        shadow_reg[recv_reg] <= fifo_rd_data;
                        if (recv_reg == LAST_IDX) begin
                            // Final word bypasses the shadow so the whole frame
                            // lands on out_sums in one update.
                            for (int i = 0; i < CHANNELS - 1; i++) begin
                                out_word_reg[i] <= shadow_reg[i];
                            end
                            out_word_reg[CHANNELS-1] <= fifo_rd_data;
                            out_valid_reg            <= 1'b1;
                            pop_state_reg            <= O_DONE;
                        end else begin
                            recv_reg <= recv_reg + IDX_W'(1);
                        end
                    end
                end
                O_DONE: begin
                    if (pop_start) begin
                        pop_overrun_reg <= 1'b1;
                    end
                    pop_state_reg <= O_IDLE;
                end
                default: pop_state_reg <= O_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_integrator_fifo_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for integrator_fifo_sequencer: directed cycle-exact scenarios plus
// a randomized run scored against a frame-level reference model and a
// queue-based external FIFO.
// ---------------------------------------------------------------------------
module tb_integrator_fifo_sequencer;

    localparam int CH    = 8;
    localparam int W     = 36;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_load = 1'b0;
    logic [CH*W-1:0] in_sums = '0;
    logic            fifo_wr_en;
    logic [W-1:0]    fifo_wr_data;
    logic            fifo_full;
    logic            pop_start = 1'b0;
    logic            fifo_rd_en;
    logic [W-1:0]    fifo_rd_data = '0;
    logic            fifo_empty;
    logic [CH*W-1:0] out_sums;
    logic            out_valid;
    logic            push_busy;
    logic            pop_busy;
    logic            load_overrun;
    logic            pop_overrun;

    logic full_force  = 1'b0;
    logic empty_force = 1'b0;
    logic load_pre    = 1'b0;

    logic [W-1:0] pre_q [$];
    logic [W-1:0] fq    [$];
    int           fq_n = 0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0]    frame [CH];
    logic [CH*W-1:0] last_out = '0;

    always #5 clk = ~clk;

    integrator_fifo_sequencer #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_load      (in_load),
        .in_sums      (in_sums),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .pop_start    (pop_start),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .out_sums     (out_sums),
        .out_valid    (out_valid),
        .push_busy    (push_busy),
        .pop_busy     (pop_busy),
        .load_overrun (load_overrun),
        .pop_overrun  (pop_overrun)
    );

    // External FIFO model: first-word-fall-through not used; read data is
    // registered one cycle after fifo_rd_en.
    assign fifo_full  = full_force  || (fq_n >= DEPTH);
    assign fifo_empty = empty_force || (fq_n == 0);

    always @(posedge clk) begin
        if (load_pre) begin
            fq.delete();
            foreach (pre_q[i]) fq.push_back(pre_q[i]);
        end else begin
            if (fifo_rd_en) begin
                if (fq.size() > 0) fifo_rd_data <= fq.pop_front();
                else               fifo_rd_data <= '1;
            end
            if (fifo_wr_en) fq.push_back(fifo_wr_data);
        end
        fq_n <= fq.size();
    end

    function automatic logic [W-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    function automatic logic [CH*W-1:0] pack_frame();
        logic [CH*W-1:0] p;
        for (int i = 0; i < CH; i++) p[i*W +: W] = frame[i];
        return p;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_load = 1'b0; pop_start = 1'b0;
        full_force = 1'b0; empty_force = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // Replace the FIFO contents with pre_q (empty pre_q flushes it).
    task automatic fifo_load();
        load_pre = 1'b1;
        next_cycle();
        load_pre = 1'b0;
    endtask

    task automatic set_preload_from_frame();
        pre_q.delete();
        for (int i = 0; i < CH; i++) pre_q.push_back(frame[i]);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({fifo_wr_en, fifo_rd_en, out_valid, push_busy, pop_busy, load_overrun, pop_overrun} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {fifo_wr_en, fifo_rd_en, out_valid, push_busy, pop_busy, load_overrun, pop_overrun});
        end
        n_cmp++;
        if (out_sums !== '0) begin
            n_bad++;
            $display("FAIL reset_out_sums: got %0h want 0", out_sums);
        end
        next_cycle();
        $display("test_reset done");
    endtask

    task automatic test_push_basic();
        int nw = 0;
        bit exp_b;
        pre_q.delete();
        fifo_load();
        for (int i = 0; i < CH; i++) frame[i] = W'(i);
        in_sums = pack_frame();
        in_load = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            in_load = 1'b0;
            @(negedge clk);
            exp_b = (k <= CH);
            n_cmp++;
            if (fifo_wr_en !== exp_b) begin
                n_bad++; $display("FAIL push_wr_en cyc=%0d: got %b want %b", k, fifo_wr_en, exp_b);
            end
            n_cmp++;
            if (push_busy !== exp_b) begin
                n_bad++; $display("FAIL push_busy cyc=%0d: got %b want %b", k, push_busy, exp_b);
            end
            if (fifo_wr_en) begin
                if (nw < CH) begin
                    n_cmp++;
                    if (fifo_wr_data !== frame[nw]) begin
                        n_bad++; $display("FAIL push_data word=%0d: got %0h want %0h", nw, fifo_wr_data, frame[nw]);
                    end
                end
                nw++;
            end
        end
        n_cmp++;
        if (nw != CH) begin
            n_bad++; $display("FAIL push_count: got %0d want %0d", nw, CH);
        end
        next_cycle();
        $display("test_push_basic done");
    endtask

    task automatic test_push_stall();
        int nw = 0;
        bit exp_b;
        pre_q.delete();
        fifo_load();
        for (int i = 0; i < CH; i++) frame[i] = W'(i);
        in_sums = pack_frame();
        in_load = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            next_cycle();
            in_load = 1'b0;
            full_force = (k >= 3 && k <= 5);
            @(negedge clk);
            exp_b = (k >= 1 && k <= 2) || (k >= 6 && k <= 11);
            n_cmp++;
            if (fifo_wr_en !== exp_b) begin
                n_bad++; $display("FAIL stall_wr_en cyc=%0d: got %b want %b", k, fifo_wr_en, exp_b);
            end
            n_cmp++;
            if (push_busy !== (k <= 11)) begin
                n_bad++; $display("FAIL stall_busy cyc=%0d: got %b want %b", k, push_busy, (k <= 11));
            end
            if (fifo_wr_en) begin
                if (nw < CH) begin
                    n_cmp++;
                    if (fifo_wr_data !== frame[nw]) begin
                        n_bad++; $display("FAIL stall_data word=%0d: got %0h want %0h", nw, fifo_wr_data, frame[nw]);
                    end
                end
                nw++;
            end
        end
        full_force = 1'b0;
        n_cmp++;
        if (nw != CH) begin
            n_bad++; $display("FAIL stall_count: got %0d want %0d", nw, CH);
        end
        next_cycle();
        $display("test_push_stall done");
    endtask

    task automatic test_pop_basic();
        for (int i = 0; i < CH; i++) frame[i] = rand_word();
        set_preload_from_frame();
        fifo_load();
        pop_start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            next_cycle();
            pop_start = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (fifo_rd_en !== (k <= CH)) begin
                n_bad++; $display("FAIL pop_rd_en cyc=%0d: got %b want %b", k, fifo_rd_en, (k <= CH));
            end
            n_cmp++;
            if (out_valid !== (k == CH + 2)) begin
                n_bad++; $display("FAIL pop_valid cyc=%0d: got %b want %b", k, out_valid, (k == CH + 2));
            end
            n_cmp++;
            if (pop_busy !== (k <= CH + 2)) begin
                n_bad++; $display("FAIL pop_busy cyc=%0d: got %b want %b", k, pop_busy, (k <= CH + 2));
            end
            n_cmp++;
            if (out_sums !== ((k >= CH + 2) ? pack_frame() : last_out)) begin
                n_bad++; $display("FAIL pop_sums cyc=%0d: got %0h want %0h", k, out_sums,
                                  (k >= CH + 2) ? pack_frame() : last_out);
            end
        end
        last_out = pack_frame();
        next_cycle();
        $display("test_pop_basic done");
    endtask

    task automatic test_pop_empty_stall();
        for (int i = 0; i < CH; i++) frame[i] = rand_word();
        set_preload_from_frame();
        fifo_load();
        pop_start   = 1'b1;
        empty_force = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            next_cycle();
            pop_start   = 1'b0;
            empty_force = (k < 4);
            @(negedge clk);
            n_cmp++;
            if (fifo_rd_en !== (k >= 4 && k <= 11)) begin
                n_bad++; $display("FAIL estall_rd_en cyc=%0d: got %b want %b", k, fifo_rd_en, (k >= 4 && k <= 11));
            end
            n_cmp++;
            if (out_valid !== (k == 13)) begin
                n_bad++; $display("FAIL estall_valid cyc=%0d: got %b want %b", k, out_valid, (k == 13));
            end
            n_cmp++;
            if (out_sums !== ((k >= 13) ? pack_frame() : last_out)) begin
                n_bad++; $display("FAIL estall_sums cyc=%0d: got %0h want %0h", k, out_sums,
                                  (k >= 13) ? pack_frame() : last_out);
            end
        end
        empty_force = 1'b0;
        last_out = pack_frame();
        next_cycle();
        $display("test_pop_empty_stall done");
    endtask

    task automatic test_overrun();
        logic [W-1:0]    c_words [CH];
        logic [CH*W-1:0] c_packed;
        logic [CH*W-1:0] junk;
        int nw = 0;
        do_reset();
        pre_q.delete();
        fifo_load();
        for (int i = 0; i < CH; i++) frame[i] = rand_word();
        c_words  = frame;
        c_packed = pack_frame();
        for (int i = 0; i < CH; i++) junk[i*W +: W] = rand_word();
        in_sums = c_packed;
        in_load = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            in_load = (k == 3);
            in_sums = (k == 3) ? junk : c_packed;
            @(negedge clk);
            n_cmp++;
            if (load_overrun !== (k >= 4)) begin
                n_bad++; $display("FAIL load_overrun cyc=%0d: got %b want %b", k, load_overrun, (k >= 4));
            end
            if (fifo_wr_en) begin
                if (nw < CH) begin
                    n_cmp++;
                    if (fifo_wr_data !== c_words[nw]) begin
                        n_bad++; $display("FAIL ovr_data word=%0d: got %0h want %0h", nw, fifo_wr_data, c_words[nw]);
                    end
                end
                nw++;
            end
        end
        in_load = 1'b0;
        n_cmp++;
        if (nw != CH) begin
            n_bad++; $display("FAIL ovr_count: got %0d want %0d", nw, CH);
        end
        next_cycle();

        for (int i = 0; i < CH; i++) frame[i] = rand_word();
        set_preload_from_frame();
        fifo_load();
        pop_start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            next_cycle();
            pop_start = (k == 3);
            @(negedge clk);
            n_cmp++;
            if (pop_overrun !== (k >= 4)) begin
                n_bad++; $display("FAIL pop_overrun cyc=%0d: got %b want %b", k, pop_overrun, (k >= 4));
            end
            n_cmp++;
            if (out_valid !== (k == CH + 2)) begin
                n_bad++; $display("FAIL ovr_valid cyc=%0d: got %b want %b", k, out_valid, (k == CH + 2));
            end
            if (k == CH + 2) begin
                n_cmp++;
                if (out_sums !== pack_frame()) begin
                    n_bad++; $display("FAIL ovr_sums: got %0h want %0h", out_sums, pack_frame());
                end
            end
        end
        pop_start = 1'b0;
        last_out = pack_frame();
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({load_overrun, pop_overrun} !== 2'b11) begin
            n_bad++; $display("FAIL flags_sticky: got %b want 11", {load_overrun, pop_overrun});
        end
        next_cycle();
        $display("test_overrun done");
    endtask

    task automatic test_reset_midframe();
        int nw = 0;
        for (int i = 0; i < CH; i++) frame[i] = rand_word();
        set_preload_from_frame();
        fifo_load();
        for (int i = 0; i < CH; i++) frame[i] = rand_word();
        in_sums   = pack_frame();
        in_load   = 1'b1;
        pop_start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            in_load   = (k == 4);
            pop_start = (k == 4);
            reset     = (k == 4);
            @(negedge clk);
            if (k <= 3) begin
                n_cmp++;
                if ({fifo_wr_en, fifo_rd_en} !== 2'b11) begin
                    n_bad++; $display("FAIL mid_active cyc=%0d: got %b want 11", k, {fifo_wr_en, fifo_rd_en});
                end
            end
            if (k >= 5) begin
                n_cmp++;
                if ({fifo_wr_en, fifo_rd_en, out_valid, push_busy, pop_busy} !== 5'b0) begin
                    n_bad++; $display("FAIL mid_quiet cyc=%0d: got %b want 00000", k,
                                      {fifo_wr_en, fifo_rd_en, out_valid, push_busy, pop_busy});
                end
            end
            if (k == 5) begin
                n_cmp++;
                if ({load_overrun, pop_overrun} !== 2'b00) begin
                    n_bad++; $display("FAIL mid_flags: got %b want 00", {load_overrun, pop_overrun});
                end
                n_cmp++;
                if (out_sums !== '0) begin
                    n_bad++; $display("FAIL mid_out_sums: got %0h want 0", out_sums);
                end
            end
        end
        last_out = '0;
        next_cycle();
        pre_q.delete();
        fifo_load();
        for (int i = 0; i < CH; i++) frame[i] = rand_word();
        in_sums = pack_frame();
        in_load = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            in_load = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (fifo_wr_en !== (k <= CH)) begin
                n_bad++; $display("FAIL fresh_wr_en cyc=%0d: got %b want %b", k, fifo_wr_en, (k <= CH));
            end
            if (fifo_wr_en) begin
                if (nw < CH) begin
                    n_cmp++;
                    if (fifo_wr_data !== frame[nw]) begin
                        n_bad++; $display("FAIL fresh_data word=%0d: got %0h want %0h", nw, fifo_wr_data, frame[nw]);
                    end
                end
                nw++;
            end
        end
        n_cmp++;
        if (nw != CH) begin
            n_bad++; $display("FAIL fresh_count: got %0d want %0d", nw, CH);
        end
        next_cycle();
        $display("test_reset_midframe done");
    endtask

    // Randomized traffic. Reference: every accepted frame appears word by word
    // on the write port, and popped frames are the pushed words taken eight
    // at a time in order. An engine is idle once all work it accepted is done.
    task automatic test_random();
        logic [W-1:0]    exp_w [$];
        logic [W-1:0]    exp_p [$];
        logic [W-1:0]    want_w;
        logic [CH*W-1:0] want;
        int acc = 0, wcount = 0, pstart = 0, prcv = 0, k = 0;
        bit bad_load = 0, bad_pop = 0, done = 0;
        bit load_acc, pop_acc, push_idle, pop_idle;
        do_reset();
        pre_q.delete();
        fifo_load();
        while (!done && k < 8000) begin
            push_idle = (wcount == acc * CH);
            pop_idle  = (pstart == prcv);
            load_acc = 0; pop_acc = 0;
            in_load = 1'b0; pop_start = 1'b0;
            full_force  = ($urandom_range(0, 3) == 0);
            empty_force = ($urandom_range(0, 3) == 0);
            if (k < 1500) begin
                if (push_idle && $urandom_range(0, 2) == 0) begin
                    for (int i = 0; i < CH; i++) frame[i] = rand_word();
                    in_sums = pack_frame(); in_load = 1'b1; load_acc = 1;
                end else if (!push_idle && $urandom_range(0, 59) == 0) begin
                    for (int i = 0; i < CH; i++) in_sums[i*W +: W] = rand_word();
                    in_load = 1'b1; bad_load = 1;
                end
            end
            if (pop_idle && (pstart < acc + int'(load_acc)) && $urandom_range(0, 3) == 0) begin
                pop_start = 1'b1; pop_acc = 1;
            end else if (!pop_idle && k < 1500 && $urandom_range(0, 59) == 0) begin
                pop_start = 1'b1; bad_pop = 1;
            end
            @(negedge clk);
            n_cmp++;
            if (push_busy !== !push_idle) begin
                n_bad++; $display("FAIL rnd_push_busy cyc=%0d: got %b want %b", k, push_busy, !push_idle);
            end
            n_cmp++;
            if (pop_busy !== !pop_idle) begin
                n_bad++; $display("FAIL rnd_pop_busy cyc=%0d: got %b want %b", k, pop_busy, !pop_idle);
            end
            if (fifo_wr_en) begin
                n_cmp++;
                if (exp_w.size() == 0) begin
                    n_bad++; $display("FAIL rnd_wr_extra cyc=%0d: got %0h want none", k, fifo_wr_data);
                end else begin
                    want_w = exp_w.pop_front();
                    if (fifo_wr_data !== want_w) begin
                        n_bad++; $display("FAIL rnd_wr_data cyc=%0d: got %0h want %0h", k, fifo_wr_data, want_w);
                    end
                end
                wcount++;
            end
            if (out_valid) begin
                want = '0;
                n_cmp++;
                if (exp_p.size() < CH) begin
                    n_bad++; $display("FAIL rnd_frame_extra cyc=%0d: got %0h want none", k, out_sums);
                end else begin
                    for (int i = 0; i < CH; i++) want[i*W +: W] = exp_p.pop_front();
                    if (out_sums !== want) begin
                        n_bad++; $display("FAIL rnd_frame cyc=%0d: got %0h want %0h", k, out_sums, want);
                    end
                end
                prcv++;
            end
            if (load_acc) begin
                acc++;
                for (int i = 0; i < CH; i++) begin
                    exp_w.push_back(frame[i]);
                    exp_p.push_back(frame[i]);
                end
            end
            if (pop_acc) pstart++;
            next_cycle();
            k++;
            done = (k >= 1500) && (wcount == acc * CH) && (pstart == prcv) && (prcv == acc);
        end
        in_load = 1'b0; pop_start = 1'b0; full_force = 1'b0; empty_force = 1'b0;
        n_cmp++;
        if (!done) begin
            n_bad++; $display("FAIL rnd_drain_timeout: got %0d frames popped want %0d", prcv, acc);
        end
        @(negedge clk);
        n_cmp++;
        if (load_overrun !== bad_load) begin
            n_bad++; $display("FAIL rnd_load_overrun: got %b want %b", load_overrun, bad_load);
        end
        n_cmp++;
        if (pop_overrun !== bad_pop) begin
            n_bad++; $display("FAIL rnd_pop_overrun: got %b want %b", pop_overrun, bad_pop);
        end
        next_cycle();
        $display("test_random done: %0d frames", acc);
    endtask

    initial begin
        test_reset();
        test_push_basic();
        test_push_stall();
        test_pop_basic();
        test_pop_empty_stall();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
